// File: rtl/stage_if.sv
// Instruction fetch stage: drives instruction memory requests and fills the IF/DE buffer.
// A skid register absorbs a response that arrives during a stall. A 2-bit BHT predicts conditional branches.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h00000060,
  parameter int          BHT_IDX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic [31:0] pc_buffer_out,
  output logic [31:0] pc_plus4_buffer_out,
  output logic [31:0] ir_data,
  output logic        prev_prediction,
  output logic        valid_out
);

  localparam int BHT_DEPTH = 1 << BHT_IDX;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic        read_q;
  logic [31:0] pcBuf_q;
  logic [31:0] pc4Buf_q;
  logic [31:0] ir_q;
  logic        pred_q;
  logic        valid_q;
  logic [31:0] skidData_q;
  logic        skidPred_q;

  logic [1:0]  bht_q [BHT_DEPTH];
  logic [1:0]  bhtEntry_d;

  logic [BHT_IDX-1:0] fetchIdx;
  logic [BHT_IDX-1:0] resolveIdx;
  logic               fetchPred;
  logic [31:0]        fetchNext;
  logic [31:0]        skidNext;
  logic               unusedBits;

  function automatic logic [31:0] bImm(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  assign fetchIdx   = pc_q[BHT_IDX+1:2];
  assign resolveIdx = resolve_pc[BHT_IDX+1:2];
  assign unusedBits = ^{resolve_pc[31:BHT_IDX+2], resolve_pc[1:0]};

  // The BHT is read before this cycle's resolve update lands, so a same-index update is not seen yet.
  always_comb begin
    fetchPred = (imem_rdata[6:0] == OPC_BRANCH) && bht_q[fetchIdx][1];
    fetchNext = fetchPred ? pc_q + bImm(imem_rdata) : pc_q + 32'd4;
    skidNext  = skidPred_q ? pc_q + bImm(skidData_q) : pc_q + 32'd4;
  end

  always_comb begin
    bhtEntry_d = bht_q[resolveIdx];
    if (resolve_taken && bhtEntry_d != 2'b11) begin
      bhtEntry_d = bhtEntry_d + 2'b01;
    end else if (!resolve_taken && bhtEntry_d != 2'b00) begin
      bhtEntry_d = bhtEntry_d - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bht_q <= '{default: 2'b01};
    end else if (resolve_valid) begin
      bht_q[resolveIdx] <= bhtEntry_d;
    end
  end

  // Fetch FSM. The PC only advances once an instruction lands in the IF/DE buffer, so in HOLD
  // pc_q is still the skid instruction's address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      target_q   <= '0;
      read_q     <= 1'b1;
      pcBuf_q    <= '0;
      pc4Buf_q   <= '0;
      ir_q       <= '0;
      pred_q     <= 1'b0;
      valid_q    <= 1'b0;
      skidData_q <= '0;
      skidPred_q <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      ir_q       <= '0;
      pred_q     <= 1'b0;
      skidData_q <= '0;
      skidPred_q <= 1'b0;
      read_q     <= 1'b1;
      // An outstanding request must complete before the redirect target can be issued.
      if (state_q != ST_HOLD && !imem_resp) begin
        target_q <= redirect_pc;
        state_q  <= ST_DRAIN;
      end else begin
        pc_q    <= redirect_pc;
        state_q <= ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_resp) begin
            if (stall) begin
              skidData_q <= imem_rdata;
              skidPred_q <= fetchPred;
              read_q     <= 1'b0;
              state_q    <= ST_HOLD;
            end else begin
              pcBuf_q  <= pc_q;
              pc4Buf_q <= pc_q + 32'd4;
              ir_q     <= imem_rdata;
              pred_q   <= fetchPred;
              valid_q  <= 1'b1;
              pc_q     <= fetchNext;
            end
          end else if (!stall) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            pred_q  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            pcBuf_q  <= pc_q;
            pc4Buf_q <= pc_q + 32'd4;
            ir_q     <= skidData_q;
            pred_q   <= skidPred_q;
            valid_q  <= 1'b1;
            pc_q     <= skidNext;
            read_q   <= 1'b1;
            state_q  <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_resp) begin
            pc_q    <= target_q;
            state_q <= ST_REQ;
          end
          if (!stall) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            pred_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_REQ;
          read_q  <= 1'b1;
        end
      endcase
    end
  end

  assign imem_read           = read_q;
  assign imem_address        = pc_q;
  assign pc_buffer_out       = pcBuf_q;
  assign pc_plus4_buffer_out = pc4Buf_q;
  assign ir_data             = ir_q;
  assign prev_prediction     = pred_q;
  assign valid_out           = valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: a directed vector table, hand-written branch predictor sequences,
// then random traffic compared against a transaction-level fetch model.
module tb_stage_if;

  localparam int BHT_N = 16;

  logic        clk = 1'b0;
  logic        rst, stall, flush, resolve_valid, resolve_taken, imem_resp;
  logic [31:0] redirect_pc, resolve_pc, imem_rdata;
  logic        imem_read, prev_prediction, valid_out;
  logic [31:0] imem_address, pc_buffer_out, pc_plus4_buffer_out, ir_data;

  always #5 clk = ~clk;

  stage_if #(.RESET_PC(32'h00000060), .BHT_IDX(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .imem_read(imem_read), .imem_address(imem_address), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .pc_buffer_out(pc_buffer_out),
    .pc_plus4_buffer_out(pc_plus4_buffer_out), .ir_data(ir_data),
    .prev_prediction(prev_prediction), .valid_out(valid_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: fetch pointer, pending-redirect and parked-instruction bookkeeping plus a counter table.
  logic [31:0] mPc, mTarget, mSkidWord, mPcb, mPc4, mIr;
  bit          mHeld, mDraining, mSkidPred, mVld, mPred;
  int          mBht [BHT_N];

  function automatic bit modelPredicts(input logic [31:0] pc, input logic [31:0] w);
    return (w[6:0] == 7'b1100011) && (mBht[(pc >> 2) % BHT_N] >= 2);
  endfunction

  function automatic logic [31:0] modelNext(input logic [31:0] pc, input logic [31:0] w, input bit taken);
    int off;
    off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    return taken ? pc + 32'(off) : pc + 32'd4;
  endfunction

  task automatic modelStep();
    bit delivered, p, wasHeld;
    int k;
    if (rst) begin
      mPc = 32'h60; mTarget = 0; mSkidWord = 0; mSkidPred = 0;
      mHeld = 0; mDraining = 0;
      mPcb = 0; mPc4 = 0; mIr = 0; mVld = 0; mPred = 0;
      for (int i = 0; i < BHT_N; i++) mBht[i] = 1;
    end else begin
      delivered = 0;
      wasHeld = mHeld;
      if (flush) begin
        mVld = 0; mIr = 0; mPred = 0; mHeld = 0;
        if (!wasHeld && !imem_resp) begin
          mTarget = redirect_pc; mDraining = 1;
        end else begin
          mPc = redirect_pc; mDraining = 0;
        end
      end else if (mHeld) begin
        if (!stall) begin
          mPcb = mPc; mPc4 = mPc + 4; mIr = mSkidWord; mPred = mSkidPred; mVld = 1;
          mPc = modelNext(mPc, mSkidWord, mSkidPred);
          mHeld = 0; delivered = 1;
        end
      end else if (mDraining) begin
        if (imem_resp) begin
          mPc = mTarget; mDraining = 0;
        end
      end else if (imem_resp) begin
        p = modelPredicts(mPc, imem_rdata);
        if (stall) begin
          mHeld = 1; mSkidWord = imem_rdata; mSkidPred = p;
        end else begin
          mPcb = mPc; mPc4 = mPc + 4; mIr = imem_rdata; mPred = p; mVld = 1;
          mPc = modelNext(mPc, imem_rdata, p);
          delivered = 1;
        end
      end
      if (!flush && !stall && !delivered) begin
        mVld = 0; mIr = 0; mPred = 0;
      end
      if (resolve_valid) begin
        k = (resolve_pc >> 2) % BHT_N;
        if (resolve_taken) mBht[k] = (mBht[k] == 3) ? 3 : mBht[k] + 1;
        else               mBht[k] = (mBht[k] == 0) ? 0 : mBht[k] - 1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic f, input logic [31:0] rd,
                               input logic rs, input logic [31:0] data,
                               input logic rv, input logic [31:0] rpc, input logic rt);
    rst = r; stall = s; flush = f; redirect_pc = rd; imem_resp = rs; imem_rdata = data;
    resolve_valid = rv; resolve_pc = rpc; resolve_taken = rt;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic fetchOnly(input logic r, input logic s, input logic f, input logic [31:0] rd,
                           input logic rs, input logic [31:0] data);
    applyStimulus(r, s, f, rd, rs, data, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, " imem_read"}, {31'b0, imem_read}, {31'b0, !mHeld});
    checkOutput({tag, " imem_address"}, imem_address, mPc);
    checkOutput({tag, " valid_out"}, {31'b0, valid_out}, {31'b0, mVld});
    checkOutput({tag, " pc_buffer"}, pc_buffer_out, mPcb);
    checkOutput({tag, " pc_plus4"}, pc_plus4_buffer_out, mPc4);
    checkOutput({tag, " ir_data"}, ir_data, mIr);
    checkOutput({tag, " prediction"}, {31'b0, prev_prediction}, {31'b0, mPred});
  endtask

  typedef struct {
    logic        r, s, f;
    logic [31:0] redir;
    logic        resp;
    logic [31:0] data;
    logic        expRead;
    logic [31:0] expAddr;
    logic        expVld;
    logic [31:0] expPcb, expPc4, expIr;
    logic        expPred;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [31:0] redir,
                              input logic resp, input logic [31:0] data, input logic eRd,
                              input logic [31:0] eAd, input logic eV, input logic [31:0] ePcb,
                              input logic [31:0] ePc4, input logic [31:0] eIr, input logic eP);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.redir = redir; v.resp = resp; v.data = data;
    v.expRead = eRd; v.expAddr = eAd; v.expVld = eV; v.expPcb = ePcb; v.expPc4 = ePc4;
    v.expIr = eIr; v.expPred = eP;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    logic [31:0] word;
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 32'h60,  1'b0, 32'h0,   32'h0,   32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h13,       1'b1, 32'h64,  1'b1, 32'h60,  32'h64,  32'h13,       1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h00100093, 1'b0, 32'h64,  1'b1, 32'h60,  32'h64,  32'h13,       1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'h64,  1'b1, 32'h60,  32'h64,  32'h13,       1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 32'h68,  1'b1, 32'h64,  32'h68,  32'h00100093, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 32'h68,  1'b0, 32'h64,  32'h68,  32'h0,        1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0,        1'b1, 32'h68,  1'b0, 32'h64,  32'h68,  32'h0,        1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hdeadbeef, 1'b1, 32'h200, 1'b0, 32'h64,  32'h68,  32'h0,        1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h13,       1'b1, 32'h204, 1'b1, 32'h200, 32'h204, 32'h13,       1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h13,       1'b1, 32'h300, 1'b0, 32'h200, 32'h204, 32'h0,        1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h00000863, 1'b0, 32'h300, 1'b0, 32'h200, 32'h204, 32'h0,        1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 32'h60,  1'b0, 32'h0,   32'h0,   32'h0,        1'b0);

    for (int i = 0; i < 12; i++) begin
      fetchOnly(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].redir, vecs[i].resp, vecs[i].data);
      checkOutput($sformatf("vec%0d imem_read", i), {31'b0, imem_read}, {31'b0, vecs[i].expRead});
      checkOutput($sformatf("vec%0d imem_address", i), imem_address, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d valid_out", i), {31'b0, valid_out}, {31'b0, vecs[i].expVld});
      checkOutput($sformatf("vec%0d pc_buffer", i), pc_buffer_out, vecs[i].expPcb);
      checkOutput($sformatf("vec%0d pc_plus4", i), pc_plus4_buffer_out, vecs[i].expPc4);
      checkOutput($sformatf("vec%0d ir_data", i), ir_data, vecs[i].expIr);
      checkOutput($sformatf("vec%0d prediction", i), {31'b0, prev_prediction}, {31'b0, vecs[i].expPred});
    end

    // Train index of 0x80 to strongly taken, then fetch beq +16 there.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    fetchOnly(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h13);
    checkOutput("redirect 0x80 address", imem_address, 32'h80);
    fetchOnly(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000863);
    checkOutput("beq trained prediction", {31'b0, prev_prediction}, 32'h1);
    checkOutput("beq trained valid", {31'b0, valid_out}, 32'h1);
    checkOutput("beq trained pc_buffer", pc_buffer_out, 32'h80);
    checkOutput("beq trained next address", imem_address, 32'h90);

    // Counter at 3 plus another taken must not wrap.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    fetchOnly(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h13);
    fetchOnly(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000863);
    checkOutput("saturate high prediction", {31'b0, prev_prediction}, 32'h1);
    checkOutput("saturate high next address", imem_address, 32'h90);

    // Counter at 0 plus another not-taken must not wrap.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h84, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h84, 1'b0);
    fetchOnly(1'b0, 1'b0, 1'b1, 32'h84, 1'b1, 32'h13);
    fetchOnly(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000863);
    checkOutput("saturate low prediction", {31'b0, prev_prediction}, 32'h0);
    checkOutput("saturate low next address", imem_address, 32'h88);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      word = $urandom;
      if ($urandom_range(0, 1) == 1) word[6:0] = 7'b1100011;
      word[8] = 1'b0;
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 19) == 0),
                    32'($urandom_range(0, 1023)) << 2,
                    ($urandom_range(0, 2) != 0),
                    word,
                    ($urandom_range(0, 2) == 0),
                    32'($urandom_range(0, 63)) << 2,
                    ($urandom_range(0, 1) == 1));
      compareModel($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
